data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Per-thread LSU front end sharing one memory port, one transaction in flight.
// Define DATA_MEM_CTRL_RR_EN for round-robin arbitration; default is fixed priority.
module data_mem_ctrl #(
  parameter int NUM_THREADS     = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_THREADS-1:0]                 read_req_addr_val,
  input  logic [NUM_THREADS*DATA_ADDR_WIDTH-1:0] read_req_addr,
  output logic [NUM_THREADS-1:0]                 read_req_rdy,
  output logic [NUM_THREADS-1:0]                 read_resp_data_val,
  output logic [NUM_THREADS*DATA_WIDTH-1:0]      read_resp_data,
  input  logic [NUM_THREADS-1:0]                 read_resp_rdy,
  input  logic [NUM_THREADS-1:0]                 write_req_val,
  input  logic [NUM_THREADS*DATA_ADDR_WIDTH-1:0] write_req_addr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0]      write_req_data,
  output logic [NUM_THREADS-1:0]                 write_req_rdy,
  output logic [NUM_THREADS-1:0]                 write_resp_val,
  output logic                                   mem_req_val,
  input  logic                                   mem_req_rdy,
  output logic                                   mem_req_wen,
  output logic [DATA_ADDR_WIDTH-1:0]             mem_req_addr,
  output logic [DATA_WIDTH-1:0]                  mem_req_data,
  input  logic                                   mem_resp_val,
  input  logic [DATA_WIDTH-1:0]                  mem_resp_data,
  output logic                                   busy
);

  localparam int N  = NUM_THREADS;
  localparam int D  = DATA_WIDTH;
  localparam int A  = DATA_ADDR_WIDTH;
  localparam int TW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [TW-1:0] id_q;
  logic          wen_q;
  logic [A-1:0]  addr_q;
  logic [D-1:0]  data_q;

  logic [N-1:0]  req_any;
  logic          gnt_vld;
  logic [TW-1:0] gnt_id;
  logic          gnt_rd;
  logic          accept;

  assign req_any = read_req_addr_val | write_req_val;

`ifdef DATA_MEM_CTRL_RR_EN
  logic [TW-1:0] ptr_q;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req_any[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = TW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (int'(gnt_id) == N - 1) ? '0
             : gnt_id + TW'(1);
    end
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_any[k]) begin
        gnt_vld = 1'b1;
        gnt_id  = TW'(k);
      end
    end
  end
`endif

  // Reads win over a same-thread write; the write stays pending.
  assign gnt_rd = read_req_addr_val[gnt_id];
  assign accept = reset && (state_q == S_IDLE) && gnt_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_REQ;
            id_q    <= gnt_id;
            wen_q   <= !gnt_rd;
            addr_q  <= gnt_rd
              ? read_req_addr[int'(gnt_id)*A +: A]
              : write_req_addr[int'(gnt_id)*A +: A];
            data_q  <= gnt_rd ? '0
              : write_req_data[int'(gnt_id)*D +: D];
          end
        end
        S_REQ: begin
          if (mem_req_rdy) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_val) begin
            state_q <= S_RESP;
            if (!wen_q) data_q <= mem_resp_data;
          end
        end
        S_RESP: begin
          if (wen_q || read_resp_rdy[id_q]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    read_req_rdy       = '0;
    write_req_rdy      = '0;
    read_resp_data_val = '0;
    read_resp_data     = '0;
    write_resp_val     = '0;
    if (accept) begin
      if (gnt_rd) read_req_rdy[gnt_id]  = 1'b1;
      else        write_req_rdy[gnt_id] = 1'b1;
    end
    if (state_q == S_RESP) begin
      if (wen_q) begin
        write_resp_val[id_q] = 1'b1;
      end else begin
        read_resp_data_val[id_q] = 1'b1;
        read_resp_data[int'(id_q)*D +: D] = data_q;
      end
    end
  end

  assign mem_req_val  = (state_q == S_REQ);
  assign mem_req_wen  = mem_req_val & wen_q;
  assign mem_req_addr = mem_req_val ? addr_q : '0;
  assign mem_req_data = mem_req_wen ? data_q : '0;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a transaction-level model.
// Arbitration expectation follows DATA_MEM_CTRL_RR_EN like the design.
module tb_data_mem_ctrl;

  localparam int N = 4;
  localparam int D = 16;
  localparam int A = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   read_req_addr_val;
  logic [N*A-1:0] read_req_addr;
  logic [N-1:0]   read_req_rdy;
  logic [N-1:0]   read_resp_data_val;
  logic [N*D-1:0] read_resp_data;
  logic [N-1:0]   read_resp_rdy;
  logic [N-1:0]   write_req_val;
  logic [N*A-1:0] write_req_addr;
  logic [N*D-1:0] write_req_data;
  logic [N-1:0]   write_req_rdy;
  logic [N-1:0]   write_resp_val;
  logic           mem_req_val;
  logic           mem_req_rdy;
  logic           mem_req_wen;
  logic [A-1:0]   mem_req_addr;
  logic [D-1:0]   mem_req_data;
  logic           mem_resp_val;
  logic [D-1:0]   mem_resp_data;
  logic           busy;

  data_mem_ctrl #(
    .NUM_THREADS(N),
    .DATA_WIDTH(D),
    .DATA_ADDR_WIDTH(A)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_req_addr_val(read_req_addr_val),
    .read_req_addr(read_req_addr),
    .read_req_rdy(read_req_rdy),
    .read_resp_data_val(read_resp_data_val),
    .read_resp_data(read_resp_data),
    .read_resp_rdy(read_resp_rdy),
    .write_req_val(write_req_val),
    .write_req_addr(write_req_addr),
    .write_req_data(write_req_data),
    .write_req_rdy(write_req_rdy),
    .write_resp_val(write_resp_val),
    .mem_req_val(mem_req_val),
    .mem_req_rdy(mem_req_rdy),
    .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val),
    .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  bit           rd_pend[N];
  bit           wr_pend[N];
  logic [A-1:0] rd_addr[N];
  logic [A-1:0] wr_addr[N];
  logic [D-1:0] wr_data[N];
  logic [D-1:0] mem_m[256];
  int           rr_ptr;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      read_req_addr_val[i]     = rd_pend[i];
      read_req_addr[i*A +: A]  = rd_addr[i];
      write_req_val[i]         = wr_pend[i];
      write_req_addr[i*A +: A] = wr_addr[i];
      write_req_data[i*D +: D] = wr_data[i];
    end
    read_resp_rdy = '0;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 1'b0;
      wr_pend[i] = 1'b0;
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int t;
`ifdef DATA_MEM_CTRL_RR_EN
      t = (rr_ptr + k) % N;
`else
      t = k;
`endif
      if (rd_pend[t] || wr_pend[t]) return t;
    end
    return -1;
  endfunction

  task automatic refill();
    int t;
    for (int i = 0; i < N; i++) begin
      if (!rd_pend[i] && $urandom_range(0, 2) == 0) begin
        rd_pend[i] = 1'b1;
        rd_addr[i] = A'($urandom);
      end
      if (!wr_pend[i] && $urandom_range(0, 2) == 0) begin
        wr_pend[i] = 1'b1;
        wr_addr[i] = A'($urandom);
        wr_data[i] = D'($urandom);
      end
    end
    if (pick() < 0) begin
      t = $urandom_range(0, N - 1);
      wr_pend[t] = 1'b1;
      wr_addr[t] = A'($urandom);
      wr_data[t] = D'($urandom);
    end
  endtask

  task automatic do_txn(bit fill, int rq_d, int rs_d,
                        int ak_d);
    int           g;
    bit           rd;
    logic [A-1:0] a;
    logic [D-1:0] wd;
    logic [D-1:0] rdat;
    logic [63:0]  one;
    logic [63:0]  ev;
    @(negedge clk);
    if (fill) refill();
    drive();
    mem_req_rdy   = 1'b0;
    mem_resp_val  = 1'($urandom_range(0, 1));
    mem_resp_data = D'($urandom);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_mreq", 64'(mem_req_val), 64'd0);
    chk("idle_wresp", 64'(write_resp_val), 64'd0);
    chk("idle_rresp", 64'(read_resp_data_val), 64'd0);
    g = pick();
    if (g < 0) return;
    rd  = rd_pend[g];
    a   = rd ? rd_addr[g] : wr_addr[g];
    wd  = wr_data[g];
    one = 64'd1 << g;
    chk("acc_rrdy", 64'(read_req_rdy), rd ? one : 64'd0);
    chk("acc_wrdy", 64'(write_req_rdy), rd ? 64'd0 : one);
    @(posedge clk);
    if (rd) rd_pend[g] = 1'b0;
    else    wr_pend[g] = 1'b0;
    rr_ptr = (g + 1) % N;
    for (int j = 0; j <= rq_d; j++) begin
      @(negedge clk);
      drive();
      mem_req_rdy   = (j == rq_d);
      mem_resp_val  = 1'($urandom_range(0, 1));
      mem_resp_data = D'($urandom);
      #1;
      chk("req_val", 64'(mem_req_val), 64'd1);
      chk("req_addr", 64'(mem_req_addr), 64'(a));
      chk("req_wen", 64'(mem_req_wen), 64'(!rd));
      if (!rd) chk("req_data", 64'(mem_req_data), 64'(wd));
      chk("req_rdys", 64'({read_req_rdy, write_req_rdy}),
          64'd0);
      chk("req_busy", 64'(busy), 64'd1);
      @(posedge clk);
    end
    rdat = mem_m[a];
    for (int j = 0; j <= rs_d; j++) begin
      @(negedge clk);
      mem_req_rdy   = 1'b0;
      mem_resp_val  = (j == rs_d);
      mem_resp_data = rd ? rdat : D'($urandom);
      #1;
      chk("wait_mreq", 64'(mem_req_val), 64'd0);
      chk("wait_resp",
          64'({read_resp_data_val, write_resp_val}), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      @(posedge clk);
    end
    if (!rd) mem_m[a] = wd;
    if (rd) begin
      for (int j = 0; j <= ak_d; j++) begin
        @(negedge clk);
        mem_resp_val     = 1'($urandom_range(0, 1));
        mem_resp_data    = D'($urandom);
        read_resp_rdy    = N'($urandom);
        read_resp_rdy[g] = (j == ak_d);
        #1;
        ev = '0;
        ev[g*D +: D] = rdat;
        chk("rresp_val", 64'(read_resp_data_val), one);
        chk("rresp_data", 64'(read_resp_data), ev);
        chk("rresp_wval", 64'(write_resp_val), 64'd0);
        chk("rresp_rdys",
            64'({read_req_rdy, write_req_rdy}), 64'd0);
        @(posedge clk);
      end
    end else begin
      @(negedge clk);
      mem_resp_val = 1'b0;
      #1;
      chk("wresp_val", 64'(write_resp_val), one);
      chk("wresp_rval", 64'(read_resp_data_val), 64'd0);
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 1'b1;
      wr_pend[i] = 1'b1;
    end
    drive();
    #2 reset = 1'b0;
    #1;
    chk("rst_rrdy", 64'(read_req_rdy), 64'd0);
    chk("rst_wrdy", 64'(write_req_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mreq", 64'(mem_req_val), 64'd0);
    @(negedge clk);
    clear_pend();
    drive();
    rr_ptr = 0;
    reset  = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rr_ptr  = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = D'($urandom);
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = '0;
      wr_addr[i] = '0;
      wr_data[i] = '0;
    end
    clear_pend();
    drive();
    reset         = 1'b0;
    mem_req_rdy   = 1'b0;
    mem_resp_val  = 1'b0;
    mem_resp_data = '0;
    do_reset();

    // Single load from thread 2, response held for 3 cycles
    mem_m[8'h10] = 16'hBEEF;
    rd_pend[2]   = 1'b1;
    rd_addr[2]   = 8'h10;
    do_txn(1'b0, 0, 0, 3);

    // Single store from thread 1, memory stalls 5 cycles
    wr_pend[1] = 1'b1;
    wr_addr[1] = 8'h20;
    wr_data[1] = 16'h1234;
    do_txn(1'b0, 5, 0, 0);

    // Read-back of the stored word from thread 0
    rd_pend[0] = 1'b1;
    rd_addr[0] = 8'h20;
    do_txn(1'b0, 0, 1, 0);

    // All four threads load at once after reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 1'b1;
      rd_addr[i] = A'(8'h40 + i);
    end
    for (int i = 0; i < N; i++) do_txn(1'b0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      do_txn(1'b1, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting on memory abandons the load
    do_reset();
    rd_pend[3] = 1'b1;
    rd_addr[3] = 8'h44;
    @(negedge clk);
    drive();
    mem_req_rdy  = 1'b1;
    mem_resp_val = 1'b0;
    @(posedge clk);
    rd_pend[3] = 1'b0;
    @(negedge clk);
    drive();
    @(posedge clk);
    @(negedge clk);
    mem_req_rdy = 1'b0;
    #1;
    chk("wait_busy_pre", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mreq", 64'(mem_req_val), 64'd0);
    chk("mid_rst_rval", 64'(read_resp_data_val), 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    rr_ptr = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      mem_resp_val  = 1'b1;
      mem_resp_data = D'($urandom);
      #1;
      chk("stray_rval", 64'(read_resp_data_val), 64'd0);
      chk("stray_busy", 64'(busy), 64'd0);
    end
    mem_resp_val = 1'b0;

    // Controller still serves traffic after the abandoned load
    do_txn(1'b1, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
